instruction_decode: RTL and testbench

- Second pipeline stage of the MIPS core. It sits directly downstream of the fetch stage and consumes its latched instruction and PC.
- It decodes the instruction, reads and writes the 32x32 register file, resolves jumps and branches in ID, detects load-use and branch hazards, and detects HALT.
- It registers everything the execute stage needs into the ID/EX latch.
- It drives stall, jump and halt back to the fetch stage.

---
 rtl/instruction_decode_pkg.sv | 56 +++++
 rtl/instruction_decode_register_file.sv | 48 ++++
 rtl/instruction_decode.sv | 215 +++++++++++++++++++++
 tb/tb_instruction_decode.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, o_ctrl bit layout and the ID/EX latch record.
package instruction_decode_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LB   = 6'h20,
                         OP_LH    = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25,
                         OP_LWU   = 6'h27, OP_SB   = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09,
                         F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;

  localparam int CTRL_REG_WRITE     = 9;
  localparam int CTRL_MEM_READ      = 8;
  localparam int CTRL_MEM_WRITE     = 7;
  localparam int CTRL_MEM_TO_REG    = 6;
  localparam int CTRL_ALU_SRC       = 5;
  localparam int CTRL_LINK          = 4;
  localparam int CTRL_MEM_WIDTH_LSB = 2;
  localparam int CTRL_MEM_UNSIGNED  = 1;
  localparam int CTRL_IMM_ZEXT      = 0;

  typedef enum logic [1:0] {
    MW_BYTE = 2'b00,
    MW_HALF = 2'b01,
    MW_WORD = 2'b11
  } mem_width_e;

  // The low two opcode bits of every load/store already encode the access size.
  function automatic mem_width_e mem_width_of(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return MW_BYTE;
      2'b01:   return MW_HALF;
      default: return MW_WORD;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] link_pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [9:0]  ctrl;
  } idex_t;

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file: two operand read ports, a debug read port, one write port with
// write-first bypass, R0 hardwired to zero, asynchronous active-low clear.
module instruction_decode_register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [NB_REG-1:0]  i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_REG-1:0]  i_raddr_a,
  input  logic [NB_REG-1:0]  i_raddr_b,
  input  logic [NB_REG-1:0]  i_dbg_addr,
  output logic [NB_DATA-1:0] o_rdata_a,
  output logic [NB_DATA-1:0] o_rdata_b,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int NREGS = 1 << NB_REG;

  logic [NB_DATA-1:0] regs_q [NREGS];
  logic [NB_DATA-1:0] regs_d [NREGS];
  logic               wr_live;

  assign wr_live = i_we && (i_waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign o_rdata_a  = (i_raddr_a == '0) ? '0 :
                      (wr_live && i_raddr_a == i_waddr) ? i_wdata : regs_q[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b == '0) ? '0 :
                      (wr_live && i_raddr_b == i_waddr) ? i_wdata : regs_q[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 :
                      (wr_live && i_dbg_addr == i_waddr) ? i_wdata : regs_q[i_dbg_addr];

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: decode, register file access, in-ID jump/branch resolution, hazard stall,
// sticky HALT and the ID/EX latch.
module instruction_decode #(
  parameter int          NB_DATA   = 32,
  parameter int          NB_REG    = 5,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_instruction,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_reg_write,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rd,
  input  logic               i_mem_reg_write,
  input  logic [NB_REG-1:0]  i_mem_rd,
  input  logic [NB_REG-1:0]  i_dbg_reg_addr,
  output logic [NB_DATA-1:0] o_dbg_reg_data,
  output logic               o_stall,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_jump_address,
  output logic               o_halt,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [NB_REG-1:0]  o_shamt,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [9:0]         o_ctrl,
  output logic [NB_DATA-1:0] o_link_pc
);
  import instruction_decode_pkg::*;

  logic [5:0]         opcode, funct;
  logic [NB_REG-1:0]  rs, rt, rd, shamt, dest;
  logic [15:0]        imm16;
  logic [25:0]        target;
  logic [NB_DATA-1:0] rs_data, rt_data, imm_sext, imm;
  logic [9:0]         ctrl;
  logic               uses_rs, uses_rt, is_branch, is_jr, is_j, is_halt;
  logic               load_use, br_stall, stall;
  logic               halt_q, halt_d;
  idex_t              idex_q, idex_d;

  assign opcode = i_instruction[31:26];
  assign rs     = i_instruction[25:21];
  assign rt     = i_instruction[20:16];
  assign rd     = i_instruction[15:11];
  assign shamt  = i_instruction[10:6];
  assign funct  = i_instruction[5:0];
  assign imm16  = i_instruction[15:0];
  assign target = i_instruction[25:0];

  instruction_decode_register_file #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we       (i_wb_we),
    .i_waddr    (i_wb_addr),
    .i_wdata    (i_wb_data),
    .i_raddr_a  (rs),
    .i_raddr_b  (rt),
    .i_dbg_addr (i_dbg_reg_addr),
    .o_rdata_a  (rs_data),
    .o_rdata_b  (rt_data),
    .o_dbg_data (o_dbg_reg_data)
  );

  always_comb begin
    ctrl      = '0;
    dest      = rt;
    uses_rs   = 1'b1;
    uses_rt   = 1'b0;
    is_branch = 1'b0;
    is_jr     = 1'b0;
    is_j      = 1'b0;
    is_halt   = (i_instruction == HALT_WORD);
    case (opcode)
      OP_RTYPE: begin
        dest    = rd;
        uses_rt = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADDU, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT: ctrl[CTRL_REG_WRITE] = 1'b1;
          F_JR: is_jr = 1'b1;
          F_JALR: begin
            is_jr                = 1'b1;
            ctrl[CTRL_REG_WRITE] = 1'b1;
            ctrl[CTRL_LINK]      = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        ctrl[CTRL_REG_WRITE]                = 1'b1;
        ctrl[CTRL_MEM_READ]                 = 1'b1;
        ctrl[CTRL_MEM_TO_REG]               = 1'b1;
        ctrl[CTRL_ALU_SRC]                  = 1'b1;
        ctrl[CTRL_MEM_WIDTH_LSB +: 2]       = mem_width_of(opcode);
        ctrl[CTRL_MEM_UNSIGNED]             = opcode[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        uses_rt                             = 1'b1;
        ctrl[CTRL_MEM_WRITE]                = 1'b1;
        ctrl[CTRL_ALU_SRC]                  = 1'b1;
        ctrl[CTRL_MEM_WIDTH_LSB +: 2]       = mem_width_of(opcode);
      end
      OP_ADDI, OP_SLTI, OP_LUI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_IMM_ZEXT]  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rt   = 1'b1;
        is_branch = 1'b1;
      end
      OP_J: begin
        uses_rs = 1'b0;
        is_j    = 1'b1;
      end
      OP_JAL: begin
        uses_rs              = 1'b0;
        is_j                 = 1'b1;
        dest                 = 5'd31;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_LINK]      = 1'b1;
      end
      default: uses_rs = 1'b0;
    endcase
  end

  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm      = ctrl[CTRL_IMM_ZEXT] ? {16'h0000, imm16} : imm_sext;

  // Branches and JR compare in ID, so any in-flight producer of their sources must retire first.
  always_comb begin
    load_use = i_ex_mem_read && (i_ex_rd != '0) &&
               ((uses_rs && i_ex_rd == rs) || (uses_rt && i_ex_rd == rt));
    br_stall = (is_branch || is_jr) &&
               ((i_ex_reg_write && i_ex_rd != '0 &&
                 (i_ex_rd == rs || (is_branch && i_ex_rd == rt))) ||
                (i_mem_reg_write && i_mem_rd != '0 &&
                 (i_mem_rd == rs || (is_branch && i_mem_rd == rt))));
    stall    = load_use || br_stall;
  end

  always_comb begin
    o_jump         = 1'b0;
    o_jump_address = '0;
    if (!stall) begin
      if (is_branch && ((rs_data == rt_data) != (opcode == OP_BNE))) begin
        o_jump         = 1'b1;
        o_jump_address = i_pc + {imm_sext[NB_DATA-3:0], 2'b00};
      end else if (is_j) begin
        o_jump         = 1'b1;
        o_jump_address = {i_pc[31:28], target, 2'b00};
      end else if (is_jr) begin
        o_jump         = 1'b1;
        o_jump_address = rs_data;
      end
    end
  end

  always_comb begin
    halt_d = halt_q || (is_halt && !stall);
    idex_d = '0;
    if (!(stall || halt_q || is_halt)) begin
      idex_d.rs_data = rs_data;
      idex_d.rt_data = rt_data;
      idex_d.imm     = imm;
      idex_d.link_pc = i_pc;
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = dest;
      idex_d.shamt   = shamt;
      idex_d.opcode  = opcode;
      idex_d.funct   = funct;
      idex_d.ctrl    = ctrl;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halt_q <= 1'b0;
      idex_q <= '0;
    end else begin
      halt_q <= halt_d;
      idex_q <= idex_d;
    end
  end

  assign o_stall   = stall;
  assign o_halt    = halt_q;
  assign o_rs_data = idex_q.rs_data;
  assign o_rt_data = idex_q.rt_data;
  assign o_imm     = idex_q.imm;
  assign o_link_pc = idex_q.link_pc;
  assign o_rs      = idex_q.rs;
  assign o_rt      = idex_q.rt;
  assign o_rd      = idex_q.rd;
  assign o_shamt   = idex_q.shamt;
  assign o_opcode  = idex_q.opcode;
  assign o_funct   = idex_q.funct;
  assign o_ctrl    = idex_q.ctrl;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for the ID stage: register file, capture, hazards, jumps, immediates, HALT and reset.
module tb_instruction_decode;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instruction, i_pc, i_wb_data, o_dbg_reg_data, o_jump_address;
  logic        i_wb_we, i_ex_reg_write, i_ex_mem_read, i_mem_reg_write;
  logic [4:0]  i_wb_addr, i_ex_rd, i_mem_rd, i_dbg_reg_addr;
  logic        o_stall, o_jump, o_halt;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_link_pc;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_opcode, o_funct;
  logic [9:0]  o_ctrl;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instruction(i_instruction), .i_pc(i_pc),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_rd(i_mem_rd),
    .i_dbg_reg_addr(i_dbg_reg_addr), .o_dbg_reg_data(o_dbg_reg_data),
    .o_stall(o_stall), .o_jump(o_jump), .o_jump_address(o_jump_address), .o_halt(o_halt),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_opcode(o_opcode), .o_funct(o_funct), .o_ctrl(o_ctrl), .o_link_pc(o_link_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    i_wb_we = 1'b1; i_wb_addr = addr; i_wb_data = data;
    tick();
    i_wb_we = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_instruction = 32'h0; i_pc = 32'h0;
    i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'h0;
    i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_ex_rd = 5'd0;
    i_mem_reg_write = 1'b0; i_mem_rd = 5'd0; i_dbg_reg_addr = 5'd5;
    tick(); tick();
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", o_halt); end
    checks++; if (o_ctrl !== 10'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 000", o_ctrl); end
    checks++; if (o_dbg_reg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h exp 0", o_dbg_reg_data); end
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_regfile_capture();
    i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hAA;
    i_instruction = enc_r(5'd5, 5'd0, 5'd3, 6'h21);
    i_pc = 32'h4;
    #1;
    checks++; if (o_dbg_reg_data !== 32'hAA) begin errors++; $display("FAIL bypass_dbg got %h exp 000000aa", o_dbg_reg_data); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL addu_stall got %b exp 0", o_stall); end
    tick();
    i_wb_we = 1'b0;
    checks++; if (o_rs_data !== 32'hAA) begin errors++; $display("FAIL addu_rs_data got %h exp 000000aa", o_rs_data); end
    checks++; if (o_rd !== 5'd3) begin errors++; $display("FAIL addu_rd got %0d exp 3", o_rd); end
    checks++; if (o_ctrl !== 10'h200) begin errors++; $display("FAIL addu_ctrl got %h exp 200", o_ctrl); end
    checks++; if (o_funct !== 6'h21) begin errors++; $display("FAIL addu_funct got %h exp 21", o_funct); end
    #1;
    checks++; if (o_dbg_reg_data !== 32'hAA) begin errors++; $display("FAIL stored_dbg got %h exp 000000aa", o_dbg_reg_data); end
    i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h1234; i_dbg_reg_addr = 5'd0;
    tick();
    i_wb_we = 1'b0;
    checks++; if (o_dbg_reg_data !== 32'h0) begin errors++; $display("FAIL r0_write got %h exp 0", o_dbg_reg_data); end
  endtask

  task automatic test_load_use();
    i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b exp 1", o_stall); end
    tick();
    checks++; if (o_ctrl !== 10'h0 || o_rd !== 5'd0) begin errors++; $display("FAIL load_use_bubble got ctrl %h rd %0d exp 000 0", o_ctrl, o_rd); end
    i_ex_rd = 5'd0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL load_use_r0 got %b exp 0", o_stall); end
    i_ex_mem_read = 1'b0;
    tick();
    checks++; if (o_ctrl !== 10'h200 || o_rd !== 5'd3) begin errors++; $display("FAIL load_use_resume got ctrl %h rd %0d exp 200 3", o_ctrl, o_rd); end
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    i_instruction = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
    i_pc = 32'h20;
    #1;
    checks++; if (o_jump !== 1'b1 || o_jump_address !== 32'h18) begin errors++; $display("FAIL beq_taken got %b %h exp 1 00000018", o_jump, o_jump_address); end
    i_ex_reg_write = 1'b1; i_ex_rd = 5'd2;
    #1;
    checks++; if (o_stall !== 1'b1 || o_jump !== 1'b0) begin errors++; $display("FAIL beq_ex_hazard got stall %b jump %b exp 1 0", o_stall, o_jump); end
    i_ex_reg_write = 1'b0; i_ex_rd = 5'd0; i_mem_reg_write = 1'b1; i_mem_rd = 5'd1;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL beq_mem_hazard got %b exp 1", o_stall); end
    i_mem_reg_write = 1'b0; i_mem_rd = 5'd0;
    i_wb_we = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'd8;
    #1;
    checks++; if (o_jump !== 1'b0 || o_jump_address !== 32'h0) begin errors++; $display("FAIL beq_not_taken got %b %h exp 0 00000000", o_jump, o_jump_address); end
    tick();
    i_wb_we = 1'b0;
    i_instruction = enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE);
    #1;
    checks++; if (o_jump !== 1'b1 || o_jump_address !== 32'h18) begin errors++; $display("FAIL bne_taken got %b %h exp 1 00000018", o_jump, o_jump_address); end
    i_instruction = enc_r(5'd5, 5'd0, 5'd0, 6'h08);
    #1;
    checks++; if (o_jump !== 1'b1 || o_jump_address !== 32'hAA) begin errors++; $display("FAIL jr_target got %b %h exp 1 000000aa", o_jump, o_jump_address); end
    tick();
  endtask

  task automatic test_jal();
    i_instruction = {6'h03, 26'h40};
    i_pc = 32'h1000_0008;
    #1;
    checks++; if (o_jump !== 1'b1 || o_jump_address !== 32'h1000_0100) begin errors++; $display("FAIL jal_target got %b %h exp 1 10000100", o_jump, o_jump_address); end
    tick();
    checks++; if (o_rd !== 5'd31) begin errors++; $display("FAIL jal_rd got %0d exp 31", o_rd); end
    checks++; if (o_link_pc !== 32'h1000_0008) begin errors++; $display("FAIL jal_link_pc got %h exp 10000008", o_link_pc); end
    checks++; if (o_ctrl !== 10'h210) begin errors++; $display("FAIL jal_ctrl got %h exp 210", o_ctrl); end
  endtask

  task automatic test_immediates();
    i_pc = 32'h40;
    i_instruction = enc_i(6'h0D, 5'd0, 5'd4, 16'h8000);
    tick();
    checks++; if (o_imm !== 32'h0000_8000 || o_ctrl !== 10'h221) begin errors++; $display("FAIL ori_imm got %h ctrl %h exp 00008000 221", o_imm, o_ctrl); end
    i_instruction = enc_i(6'h08, 5'd0, 5'd4, 16'h8000);
    tick();
    checks++; if (o_imm !== 32'hFFFF_8000 || o_ctrl !== 10'h220 || o_rd !== 5'd4) begin errors++; $display("FAIL addi_imm got %h ctrl %h rd %0d exp ffff8000 220 4", o_imm, o_ctrl, o_rd); end
    i_instruction = enc_i(6'h24, 5'd5, 5'd6, 16'h0004);
    tick();
    checks++; if (o_ctrl !== 10'h362 || o_rd !== 5'd6) begin errors++; $display("FAIL lbu_ctrl got %h rd %0d exp 362 6", o_ctrl, o_rd); end
    i_instruction = enc_i(6'h2B, 5'd5, 5'd1, 16'h0008);
    tick();
    checks++; if (o_ctrl !== 10'h0AC || o_rt_data !== 32'd7) begin errors++; $display("FAIL sw_ctrl got %h rt_data %h exp 0ac 00000007", o_ctrl, o_rt_data); end
  endtask

  task automatic test_halt();
    i_instruction = 32'hFFFF_FFFF;
    #1;
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", o_halt); end
    tick();
    checks++; if (o_halt !== 1'b1 || o_ctrl !== 10'h0) begin errors++; $display("FAIL halt_set got %b ctrl %h exp 1 000", o_halt, o_ctrl); end
    i_instruction = enc_i(6'h0D, 5'd0, 5'd4, 16'h1234);
    i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h55;
    tick();
    i_wb_we = 1'b0; i_dbg_reg_addr = 5'd7;
    #1;
    checks++; if (o_halt !== 1'b1 || o_imm !== 32'h0) begin errors++; $display("FAIL halt_sticky got %b imm %h exp 1 00000000", o_halt, o_imm); end
    checks++; if (o_dbg_reg_data !== 32'h55) begin errors++; $display("FAIL halt_wb_drain got %h exp 00000055", o_dbg_reg_data); end
  endtask

  task automatic test_reset_mid_run();
    i_instruction = enc_r(5'd5, 5'd0, 5'd3, 6'h21);
    i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
    #2;
    i_reset = 1'b0;
    #1;
    checks++; if (o_halt !== 1'b0 || o_ctrl !== 10'h0) begin errors++; $display("FAIL midrst_state got halt %b ctrl %h exp 0 000", o_halt, o_ctrl); end
    checks++; if (o_dbg_reg_data !== 32'h0) begin errors++; $display("FAIL midrst_r7 got %h exp 0", o_dbg_reg_data); end
    i_dbg_reg_addr = 5'd5;
    #1;
    checks++; if (o_dbg_reg_data !== 32'h0) begin errors++; $display("FAIL midrst_r5 got %h exp 0", o_dbg_reg_data); end
    i_ex_mem_read = 1'b0; i_ex_rd = 5'd0;
    i_reset = 1'b1;
    tick();
    checks++; if (o_halt !== 1'b0 || o_rs_data !== 32'h0 || o_ctrl !== 10'h200) begin errors++; $display("FAIL post_reset got halt %b rs_data %h ctrl %h exp 0 0 200", o_halt, o_rs_data, o_ctrl); end
  endtask

  initial begin
    test_reset();
    test_regfile_capture();
    test_load_use();
    test_branch();
    test_jal();
    test_immediates();
    test_halt();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
